// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the datapath hazard-detect logic and the sequencer.
// master: datapath side (drives hazard terms); slave: sequencer side (drives enables/flushes/perf).
interface pipeline_hazard_controller_if;
   logic        load_use;
   logic        branch_taken;
   logic        mem_busy;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exmem_we;
   logic [31:0] stall_cycles;
   logic [31:0] flush_cycles;

   modport master (
      output load_use, branch_taken, mem_busy,
      input  pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, stall_cycles, flush_cycles
   );

   modport slave (
      input  load_use, branch_taken, mem_busy,
      output pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, stall_cycles, flush_cycles
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipe; perf counters enabled by HAZARD_PERF_CNT_EN.
// Latency: controls are Mealy (same cycle as hazard terms); state/cnt advance on posedge clk.
// Backpressure: mem_busy freezes every stage enable and holds the sequencer state.
module pipeline_hazard_controller #(
   parameter int LOAD_LATENCY   = 1,
   parameter int BRANCH_PENALTY = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   pipeline_hazard_controller_if.slave      hz
);

   if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7) begin : g_bad_load_latency
      $error("LOAD_LATENCY must be in 1..7");
   end
   if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 7) begin : g_bad_branch_penalty
      $error("BRANCH_PENALTY must be in 1..7");
   end

   typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_t;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_we;
   } ctl_t;

   localparam ctl_t CTL_RUN    = ctl_t'(5'b11001);
   localparam ctl_t CTL_BR     = ctl_t'(5'b11111);
   localparam ctl_t CTL_LU     = ctl_t'(5'b00011);
   localparam ctl_t CTL_FREEZE = ctl_t'(5'b00000);
   localparam ctl_t CTL_RST    = ctl_t'(5'b00110);

   localparam bit       LU_MULTI = (LOAD_LATENCY > 1);
   localparam bit       BR_MULTI = (BRANCH_PENALTY > 1);
   localparam logic [2:0] LU_CNT = 3'(LOAD_LATENCY - 1);
   localparam logic [2:0] BR_CNT = 3'(BRANCH_PENALTY - 1);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   ctl_t       ctl;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!hz.mem_busy) begin
         unique case (state_q)
            RUN, LU_STALL: begin
               // A taken branch squashes the ID instruction, so it overrides any load-use stall.
               if (hz.branch_taken) begin
                  if (BR_MULTI) begin
                     state_d = BR_FLUSH;
                     cnt_d   = BR_CNT;
                  end else begin
                     state_d = RUN;
                     cnt_d   = 3'd0;
                  end
               end else if (state_q == RUN) begin
                  if (hz.load_use && LU_MULTI) begin
                     state_d = LU_STALL;
                     cnt_d   = LU_CNT;
                  end
               end else if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            BR_FLUSH: begin
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      ctl = CTL_RUN;
      if (reset) begin
         ctl = CTL_RST;
      end else if (hz.mem_busy) begin
         ctl = CTL_FREEZE;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hz.branch_taken)  ctl = CTL_BR;
               else if (hz.load_use) ctl = CTL_LU;
            end
            LU_STALL: ctl = hz.branch_taken ? CTL_BR : CTL_LU;
            BR_FLUSH: ctl = CTL_BR;
            default:  ctl = CTL_RUN;
         endcase
      end
   end

   assign hz.pc_we      = ctl.pc_we;
   assign hz.ifid_we    = ctl.ifid_we;
   assign hz.ifid_flush = ctl.ifid_flush;
   assign hz.idex_flush = ctl.idex_flush;
   assign hz.exmem_we   = ctl.exmem_we;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= 32'h0;
         flush_q <= 32'h0;
      end else begin
         if (!ctl.pc_we && stall_q != 32'hFFFF_FFFF)     stall_q <= stall_q + 32'd1;
         if (ctl.ifid_flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
      end
   end

   assign hz.stall_cycles = stall_q;
   assign hz.flush_cycles = flush_q;
`else
   assign hz.stall_cycles = 32'h0;
   assign hz.flush_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Vector bench for pipeline_hazard_controller with LOAD_LATENCY=2, BRANCH_PENALTY=3.
module tb_pipeline_hazard_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_controller_if hz();

   pipeline_hazard_controller #(
      .LOAD_LATENCY   (2),
      .BRANCH_PENALTY (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we}
   localparam logic [4:0] RST = 5'b00110;
   localparam logic [4:0] NRM = 5'b11001;
   localparam logic [4:0] BRO = 5'b11111;
   localparam logic [4:0] STL = 5'b00011;
   localparam logic [4:0] BSY = 5'b00000;

   typedef struct {
      logic       rst;
      logic       lu;
      logic       br;
      logic       mb;
      logic [4:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [4:0]  sb_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] exp_stall = 32'h0;
   logic [31:0] exp_flush = 32'h0;

   function automatic void add(input logic r, input logic l, input logic b,
                               input logic m, input logic [4:0] e);
      vec_t v;
      v.rst = r; v.lu = l; v.br = b; v.mb = m; v.exp = e;
      tbl.push_back(v);
   endfunction

   function automatic logic [4:0] outs();
      return {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_flush, hz.exmem_we};
   endfunction

   task automatic check_ctl(input string name, input logic [4:0] want);
      logic [4:0] got;
      got = outs();
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic check_perf(input string name, input logic [31:0] st, input logic [31:0] fl);
      n_vec++;
      if (hz.stall_cycles !== st || hz.flush_cycles !== fl) begin
         n_bad++;
         $display("FAIL %s: stall=%0d flush=%0d want stall=%0d flush=%0d",
                  name, hz.stall_cycles, hz.flush_cycles, st, fl);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [4:0] want;
      @(posedge clk);
      #1;
      reset           = v.rst;
      hz.load_use     = v.lu;
      hz.branch_taken = v.br;
      hz.mem_busy     = v.mb;
      sb_q.push_back(v.exp);
      @(negedge clk);
      want = sb_q.pop_front();
      check_ctl($sformatf("ctl[%0d]", idx), want);
      check_perf($sformatf("perf[%0d]", idx), exp_stall, exp_flush);
      if (PERF) begin
         if (v.rst) begin
            exp_stall = 32'h0;
            exp_flush = 32'h0;
         end else begin
            if (!want[4]) exp_stall = exp_stall + 32'd1;
            if (want[2])  exp_flush = exp_flush + 32'd1;
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      hz.load_use     = 1'b0;
      hz.branch_taken = 1'b0;
      hz.mem_busy     = 1'b0;

      //   rst   lu    br    mb
      add(1'b1, 1'b0, 1'b0, 1'b0, RST);   // second reset cycle
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);   // first cycle after release
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b1, 1'b0, 1'b0, STL);   // load-use: two bubble cycles
      add(1'b0, 1'b0, 1'b0, 1'b0, STL);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b0, 1'b1, 1'b0, BRO);   // branch: three flush cycles, load_use ignored
      add(1'b0, 1'b1, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b1, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b1, 1'b1, 1'b0, BRO);   // simultaneous: branch wins
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b1, 1'b0, 1'b0, STL);   // branch pre-empts LU_STALL
      add(1'b0, 1'b0, 1'b1, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b0, 1'b1, 1'b0, BRO);   // mem_busy x4 in BR_FLUSH with cnt=2
      add(1'b0, 1'b0, 1'b0, 1'b1, BSY);
      add(1'b0, 1'b1, 1'b1, 1'b1, BSY);
      add(1'b0, 1'b0, 1'b0, 1'b1, BSY);
      add(1'b0, 1'b0, 1'b0, 1'b1, BSY);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b1, 1'b0, 1'b0, STL);   // mem_busy inside LU_STALL
      add(1'b0, 1'b0, 1'b0, 1'b1, BSY);
      add(1'b0, 1'b0, 1'b0, 1'b0, STL);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b0, 1'b1, 1'b0, 1'b1, BSY);   // mem_busy masks load_use in RUN
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);
      add(1'b1, 1'b0, 1'b1, 1'b1, RST);   // reset beats everything
      add(1'b0, 1'b1, 1'b0, 1'b0, STL);   // perf run: 5 stall + 3 flush cycles
      add(1'b0, 1'b0, 1'b0, 1'b0, STL);
      add(1'b0, 1'b1, 1'b0, 1'b0, STL);
      add(1'b0, 1'b0, 1'b0, 1'b0, STL);
      add(1'b0, 1'b0, 1'b0, 1'b1, BSY);
      add(1'b0, 1'b0, 1'b1, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, BRO);
      add(1'b0, 1'b0, 1'b0, 1'b0, NRM);

      @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      check_perf("perf_after_5stall_3flush",
                 PERF ? 32'd5 : 32'd0, PERF ? 32'd3 : 32'd0);

      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_ctl("reset_forced", RST);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_ctl("post_reset_run", NRM);
      check_perf("perf_cleared", 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
